spi_slave_transmitter: RTL and testbench
========================================

Name: spi_slave_transmitter

Overview:
- SD-card SPI-mode slave transmit engine; the response path paired with the command receiver.
- Produces the MISO byte stream: R1 response byte, then an optional data block (start token 0xFE, N data bytes, CRC16).
- Works entirely in the system clock domain. A separate bit shifter on the SPI clock serialises io_OutputBuffer MSB-first and pulses io_ByteSlot at each byte boundary.

Parameters:
- BLOCK_LEN_W, 12, width of the block-length input; max block 4095 bytes.
- FILL_BYTE, 8'hFF, byte presented whenever nothing is being sent.

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- io_Start  input  1  one-cycle request to begin a transaction
- io_Response  input  8  R1 byte, sampled on an accepted io_Start
- io_SendData  input  1  sampled on an accepted io_Start; 1 = data block follows the response
- io_DataBlockSize  input  BLOCK_LEN_W  block length in bytes, sampled on an accepted io_Start
- io_DataIn  input  8  next data byte from the source
- io_DataValid  input  1  io_DataIn holds a valid byte
- io_DataReady  output  1  one-cycle pulse: io_DataIn consumed this cycle
- io_ByteSlot  input  1  one-cycle pulse from the shifter: current io_OutputBuffer consumed
- io_Cancel  input  1  chip select deasserted; abort the transaction
- io_OutputBuffer  output  8  registered byte for the shifter
- io_Busy  output  1  state != IDLE
- io_Done  output  1  one-cycle pulse when the transaction completes normally
- io_Underrun  output  1  sticky; cleared by an accepted io_Start

Behaviour:
- Reset (asynchronous, active-low) values:
  - state = IDLE
  - io_OutputBuffer = FILL_BYTE
  - io_DataReady, io_Done, io_Underrun, io_Busy = 0
  - byte counter = 0, CRC register = 0
- States: IDLE, RESP, TOKEN, DATA, CRC_HI, CRC_LO.
- IDLE:
  - io_Start is accepted only in IDLE; it is ignored in every other state.
  - On io_Start: latch io_SendData and io_DataBlockSize, clear io_Underrun and CRC, load io_OutputBuffer = io_Response (latency 1 cycle), go to RESP.
- Every transition below occurs only on io_ByteSlot. The slot consumes the current byte and loads the next one.
- RESP:
  - If SendData = 1: load 8'hFE, go to TOKEN.
  - Else: load FILL_BYTE, pulse io_Done, go to IDLE.
- TOKEN:
  - If block size = 0: load CRC[15:8], go to CRC_HI; CRC of an empty block = 16'h0000.
  - Else: load the first data byte, set counter = 1, go to DATA.
- DATA:
  - If counter == block size: load CRC[15:8], go to CRC_HI.
  - Else: load the next data byte, counter += 1.
- Data byte load rule:
  - If io_DataValid = 1: load io_DataIn, pulse io_DataReady that cycle, update CRC with the byte.
  - If io_DataValid = 0: load FILL_BYTE, set io_Underrun; CRC is still updated with 0xFF and the counter still advances (the block length is preserved).
- CRC_HI: load CRC[7:0], go to CRC_LO.
- CRC_LO: load FILL_BYTE, pulse io_Done, go to IDLE.
- CRC16: polynomial 0x1021, init 0x0000, MSB-first, byte-parallel update in the cycle the byte is loaded.
- Counter is BLOCK_LEN_W bits; it never wraps because the compare precedes the increment.
- Simultaneous events:
  - io_Cancel beats everything. Next cycle: state IDLE, io_OutputBuffer = FILL_BYTE, no io_Done, io_Underrun retained.
  - io_Start together with io_ByteSlot in IDLE: the start is accepted; the slot consumes the fill byte.
  - io_Start together with io_Cancel: the start is dropped.
- io_DataReady is never asserted outside DATA/TOKEN slot cycles.

Optional Feature:
- Macro SPI_TX_CRC16_EN.
  - Defined: CRC16 computed as specified.
  - Undefined: no CRC logic; CRC_HI and CRC_LO send 8'hFF, 8'hFF (SD CRC-off mode).

Decomposition:
- Shared package spi_pkg holds:
  - state enum
  - START_TOKEN = 8'hFE, FILL_BYTE default 8'hFF
  - CRC16_POLY = 16'h1021
- One sub-module: spi_crc16_byte, a combinational next-CRC from (crc, byte). It is reusable by the receiver for data-write blocks.

Test Plan:
- Response only: Start with Response = 8'h01, SendData = 0 → OutputBuffer = 01 one cycle later; after one slot = FF with io_Done pulse; io_Busy low.
- Data block: Response 8'h00, SendData = 1, block size 9, bytes "123456789" (0x31..0x39) always valid → slot sequence 00, FE, 31..39, 31, C3, then FF; 9 io_DataReady pulses; io_Done once.
- Same block without SPI_TX_CRC16_EN → the two CRC bytes are FF, FF; all other bytes identical.
- Underrun: block size 4, io_DataValid low at the 3rd data slot → that byte = FF, io_Underrun = 1 until the next Start; total bytes still 4 + token + CRC.
- Cancel mid-DATA after 2 bytes → next cycle state IDLE, OutputBuffer FF, no io_Done; a subsequent Start with 8'h05 is accepted normally.
- Asynchronous reset asserted mid-CRC_HI between clock edges → outputs go to reset values immediately; io_Start during RESP is ignored (response byte unchanged).

Source files
------------

// File: rtl/spi_pkg.sv
// ----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SD-card SPI-mode slave datapath (transmitter and
// command receiver): transmitter state encoding, protocol byte constants and
// the CRC16 polynomial.
// ----------------------------------------------------------------------------
package spi_pkg;

    // Transmit engine states, in the order bytes leave the slave.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RESP   = 3'd1,
        ST_TOKEN  = 3'd2,
        ST_DATA   = 3'd3,
        ST_CRC_HI = 3'd4,
        ST_CRC_LO = 3'd5
    } tx_state_e;

    localparam logic [7:0]  START_TOKEN       = 8'hFE;  // single-block data start token
    localparam logic [7:0]  FILL_BYTE_DEFAULT = 8'hFF;  // idle level of MISO
    localparam logic [15:0] CRC16_POLY        = 16'h1021;

endpackage

// File: rtl/spi_crc16_byte.sv
// ----------------------------------------------------------------------------
// spi_crc16_byte
// Combinational byte-parallel CRC16-CCITT step (poly 0x1021, MSB first).
// Given the running CRC and the next byte, returns the updated CRC.
//
// Ports:
//   crc_i   [15:0]  running CRC before this byte
//   byte_i  [7:0]   byte entering the CRC, MSB first
//   crc_o   [15:0]  CRC after absorbing byte_i
// ----------------------------------------------------------------------------
module spi_crc16_byte
    import spi_pkg::*;
(
    input  logic [15:0] crc_i,
    input  logic [7:0]  byte_i,
    output logic [15:0] crc_o
);

    logic [15:0] c;

    // The byte is folded into the top of the register once, then eight
    // shift/conditional-xor steps are unrolled by the loop.
    always_comb begin
        // NOTE: blocking assignments here are intentional; each loop step must
        // see the value produced by the previous step within the same pass.
        c = crc_i ^ {byte_i, 8'h00};
        for (int i = 0; i < 8; i++) begin
            if (c[15]) c = {c[14:0], 1'b0} ^ CRC16_POLY;
            else       c = {c[14:0], 1'b0};
        end
        crc_o = c;
    end

endmodule

// File: rtl/spi_slave_transmitter.sv
// ----------------------------------------------------------------------------
// spi_slave_transmitter
// SD-card SPI-mode slave transmit engine. Builds the MISO byte stream for one
// transaction: R1 response, then optionally a data block (start token 0xFE,
// N data bytes, CRC16). One byte at a time is held in io_OutputBuffer; the
// SPI-clock shifter pulses io_ByteSlot when it takes that byte, and the engine
// loads the next one on the same system-clock edge.
//
// Build option:
//   SPI_TX_CRC16_EN  defined   -> CRC16 (0x1021, init 0) sent after the block
//                    undefined -> no CRC logic, CRC bytes are sent as FF FF
//
// Ports:
//   clock              system clock
//   reset              asynchronous, active-low reset
//   io_Start           one-cycle transaction request (accepted only in IDLE)
//   io_Response  [7:0] R1 byte, sampled on an accepted start
//   io_SendData        1 = data block follows the response
//   io_DataBlockSize   block length in bytes (0 = token + CRC only)
//   io_DataIn    [7:0] next data byte from the source
//   io_DataValid       io_DataIn holds a valid byte
//   io_DataReady       io_DataIn consumed this cycle
//   io_ByteSlot        shifter consumed io_OutputBuffer this cycle
//   io_Cancel          chip select deasserted; abort immediately
//   io_OutputBuffer    registered byte presented to the shifter
//   io_Busy            engine not in IDLE
//   io_Done            one-cycle pulse after a transaction completes normally
//   io_Underrun        sticky: a data byte was missing and FILL was sent
// ----------------------------------------------------------------------------
module spi_slave_transmitter
    import spi_pkg::*;
#(
    parameter int         BLOCK_LEN_W = 12,
    parameter logic [7:0] FILL_BYTE   = FILL_BYTE_DEFAULT
)
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   io_Start,
    input  logic [7:0]             io_Response,
    input  logic                   io_SendData,
    input  logic [BLOCK_LEN_W-1:0] io_DataBlockSize,
    input  logic [7:0]             io_DataIn,
    input  logic                   io_DataValid,
    output logic                   io_DataReady,
    input  logic                   io_ByteSlot,
    input  logic                   io_Cancel,
    output logic [7:0]             io_OutputBuffer,
    output logic                   io_Busy,
    output logic                   io_Done,
    output logic                   io_Underrun
);

    localparam logic [BLOCK_LEN_W-1:0] CNT_ZERO = '0;
    localparam logic [BLOCK_LEN_W-1:0] CNT_ONE  = 1;

    tx_state_e              state_q, state_d;
    logic [7:0]             out_q, out_d;
    logic                   send_q, send_d;
    logic [BLOCK_LEN_W-1:0] len_q, len_d;
    logic [BLOCK_LEN_W-1:0] cnt_q, cnt_d;
    logic                   underrun_q, underrun_d;
    logic                   done_q, done_d;

    logic                   fetch;       // a data byte is loaded this cycle
    logic [7:0]             fetch_byte;  // byte loaded on a fetch (FILL on underrun)
    logic                   last_data;   // every block byte has been loaded
    logic [7:0]             crc_hi, crc_lo;

    assign fetch_byte = io_DataValid ? io_DataIn : FILL_BYTE;
    // Compare before increment: the counter never needs to hold len+1.
    assign last_data  = (cnt_q == len_q);

`ifdef SPI_TX_CRC16_EN
    logic [15:0] crc_q, crc_d, crc_next;

    spi_crc16_byte u_crc (
        .crc_i  (crc_q),
        .byte_i (fetch_byte),
        .crc_o  (crc_next)
    );

    assign crc_hi = crc_q[15:8];
    assign crc_lo = crc_q[7:0];
`else
    // SD CRC-off mode: the CRC field is transmitted as all ones.
    assign crc_hi = 8'hFF;
    assign crc_lo = 8'hFF;
`endif

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            out_q      <= FILL_BYTE;
            send_q     <= 1'b0;
            len_q      <= CNT_ZERO;
            cnt_q      <= CNT_ZERO;
            underrun_q <= 1'b0;
            done_q     <= 1'b0;
`ifdef SPI_TX_CRC16_EN
            crc_q      <= 16'h0000;
`endif
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values,
            // independent of statement order.
            state_q    <= state_d;
            out_q      <= out_d;
            send_q     <= send_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            underrun_q <= underrun_d;
            done_q     <= done_d;
`ifdef SPI_TX_CRC16_EN
            crc_q      <= crc_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Cancel wins over everything, including a start.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (io_Cancel) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE:   if (io_Start)    state_d = ST_RESP;
                ST_RESP:   if (io_ByteSlot) state_d = send_q ? ST_TOKEN : ST_IDLE;
                ST_TOKEN:  if (io_ByteSlot) state_d = (len_q == CNT_ZERO) ? ST_CRC_HI : ST_DATA;
                ST_DATA:   if (io_ByteSlot && last_data) state_d = ST_CRC_HI;
                ST_CRC_HI: if (io_ByteSlot) state_d = ST_CRC_LO;
                ST_CRC_LO: if (io_ByteSlot) state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output / datapath logic: what is loaded into the buffer on each slot.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        out_d      = out_q;
        send_d     = send_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        underrun_d = underrun_q;
        done_d     = 1'b0;
        fetch      = 1'b0;
`ifdef SPI_TX_CRC16_EN
        crc_d      = crc_q;
`endif

        if (io_Cancel) begin
            // Abort: idle level on MISO, no done pulse, underrun kept.
            out_d = FILL_BYTE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (io_Start) begin
                        out_d      = io_Response;
                        send_d     = io_SendData;
                        len_d      = io_DataBlockSize;
                        cnt_d      = CNT_ZERO;
                        underrun_d = 1'b0;
`ifdef SPI_TX_CRC16_EN
                        crc_d      = 16'h0000;
`endif
                    end
                end
                ST_RESP: begin
                    if (io_ByteSlot) begin
                        out_d  = send_q ? START_TOKEN : FILL_BYTE;
                        done_d = !send_q;
                    end
                end
                ST_TOKEN: begin
                    if (io_ByteSlot) begin
                        if (len_q == CNT_ZERO) begin
                            out_d = crc_hi;
                        end else begin
                            fetch = 1'b1;
                            cnt_d = CNT_ONE;
                        end
                    end
                end
                ST_DATA: begin
                    if (io_ByteSlot) begin
                        if (last_data) begin
                            out_d = crc_hi;
                        end else begin
                            fetch = 1'b1;
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                end
                ST_CRC_HI: begin
                    if (io_ByteSlot) out_d = crc_lo;
                end
                ST_CRC_LO: begin
                    if (io_ByteSlot) begin
                        out_d  = FILL_BYTE;
                        done_d = 1'b1;
                    end
                end
                default: out_d = FILL_BYTE;
            endcase

            // A missing source byte is replaced by FILL but still counted and
            // still folded into the CRC so the block length is preserved.
            if (fetch) begin
                out_d = fetch_byte;
                if (!io_DataValid) underrun_d = 1'b1;
`ifdef SPI_TX_CRC16_EN
                crc_d = crc_next;
`endif
            end
        end
    end

    assign io_DataReady    = fetch && io_DataValid;
    assign io_OutputBuffer = out_q;
    assign io_Busy         = (state_q != ST_IDLE);
    assign io_Done         = done_q;
    assign io_Underrun     = underrun_q;

endmodule

// File: tb/tb_spi_slave_transmitter.sv
// ----------------------------------------------------------------------------
// tb_spi_slave_transmitter
// Directed bench for spi_slave_transmitter. Inputs are driven 1 ns after the
// rising edge; outputs are sampled before the next rising edge. Expected CRC
// bytes follow the SPI_TX_CRC16_EN build option.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_slave_transmitter;

    logic        clock = 1'b0;
    logic        reset;
    logic        io_Start;
    logic [7:0]  io_Response;
    logic        io_SendData;
    logic [11:0] io_DataBlockSize;
    logic [7:0]  io_DataIn;
    logic        io_DataValid;
    logic        io_DataReady;
    logic        io_ByteSlot;
    logic        io_Cancel;
    logic [7:0]  io_OutputBuffer;
    logic        io_Busy;
    logic        io_Done;
    logic        io_Underrun;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    spi_slave_transmitter dut (
        .clock            (clock),
        .reset            (reset),
        .io_Start         (io_Start),
        .io_Response      (io_Response),
        .io_SendData      (io_SendData),
        .io_DataBlockSize (io_DataBlockSize),
        .io_DataIn        (io_DataIn),
        .io_DataValid     (io_DataValid),
        .io_DataReady     (io_DataReady),
        .io_ByteSlot      (io_ByteSlot),
        .io_Cancel        (io_Cancel),
        .io_OutputBuffer  (io_OutputBuffer),
        .io_Busy          (io_Busy),
        .io_Done          (io_Done),
        .io_Underrun      (io_Underrun)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bit-serial reference CRC16 (0x1021, MSB first).
    function automatic logic [15:0] crc_ref(input logic [15:0] c, input logic [7:0] b);
        logic fb;
        for (int i = 7; i >= 0; i--) begin
            fb = c[15] ^ b[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    // CRC field as it appears on the wire for this build.
    function automatic logic [15:0] crc_wire(input logic [15:0] c);
`ifdef SPI_TX_CRC16_EN
        return c;
`else
        return (c & 16'h0000) | 16'hFFFF;
`endif
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start(input logic [7:0] resp, input logic send, input logic [11:0] len);
        io_Start = 1'b1; io_Response = resp; io_SendData = send; io_DataBlockSize = len;
        tick();
        io_Start = 1'b0;
    endtask

    // One shifter slot: report the byte consumed and whether the source byte was taken.
    task automatic do_slot(input logic valid, input logic [7:0] din,
                           output logic [7:0] consumed, output logic rdy);
        io_ByteSlot = 1'b1; io_DataValid = valid; io_DataIn = din;
        #1;
        consumed = io_OutputBuffer;
        rdy      = io_DataReady;
        tick();
        io_ByteSlot = 1'b0; io_DataValid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  got;
        logic        rdy;
        logic [7:0]  blk [10];
        logic [7:0]  exp_seq [13];
        logic [7:0]  src [4];
        logic [7:0]  exp_u [8];
        logic [15:0] c;
        int k, n_rdy, n_done;

        reset = 1'b0; io_Start = 1'b0; io_Response = 8'h00; io_SendData = 1'b0;
        io_DataBlockSize = '0; io_DataIn = 8'h00; io_DataValid = 1'b0;
        io_ByteSlot = 1'b0; io_Cancel = 1'b0;
        #12;
        check("rst_buf",  io_OutputBuffer, 8'hFF);
        check("rst_busy", io_Busy, 1'b0);
        check("rst_done", io_Done, 1'b0);
        check("rst_und",  io_Underrun, 1'b0);
        check("rst_rdy",  io_DataReady, 1'b0);
        tick();
        reset = 1'b1;
        tick();

        // ---- Response only ----
        start(8'h01, 1'b0, 12'd0);
        check("r1_buf", io_OutputBuffer, 8'h01);
        check("r1_busy", io_Busy, 1'b1);
        do_slot(1'b0, 8'h00, got, rdy);
        check("r1_sent", got, 8'h01);
        check("r1_after", io_OutputBuffer, 8'hFF);
        check("r1_done", io_Done, 1'b1);
        check("r1_idle", io_Busy, 1'b0);
        tick();
        check("r1_done_pulse", io_Done, 1'b0);

        // ---- Data block "123456789" ----
        for (int i = 0; i < 10; i++) blk[i] = 8'h31 + 8'(i);
        exp_seq[0] = 8'h00; exp_seq[1] = 8'hFE;
        for (int i = 0; i < 9; i++) exp_seq[2+i] = 8'h31 + 8'(i);
        c = crc_wire(16'h31C3);
        exp_seq[11] = c[15:8]; exp_seq[12] = c[7:0];
        start(8'h00, 1'b1, 12'd9);
        k = 0; n_rdy = 0; n_done = 0;
        for (int i = 0; i < 13; i++) begin
            do_slot(1'b1, blk[k], got, rdy);
            if (rdy) begin n_rdy++; if (k < 9) k++; end
            if (io_Done) n_done++;
            check($sformatf("blk_byte%0d", i), got, exp_seq[i]);
        end
        check("blk_rdy_count", n_rdy, 9);
        check("blk_done_count", n_done, 1);
        check("blk_buf_fill", io_OutputBuffer, 8'hFF);
        check("blk_idle", io_Busy, 1'b0);
        check("blk_no_und", io_Underrun, 1'b0);
        tick();

        // ---- Underrun at the 3rd data byte ----
        src[0] = 8'hA1; src[1] = 8'hA2; src[2] = 8'hA3; src[3] = 8'hA4;
        c = 16'h0000;
        c = crc_ref(c, 8'hA1); c = crc_ref(c, 8'hA2);
        c = crc_ref(c, 8'hFF); c = crc_ref(c, 8'hA3);
        c = crc_wire(c);
        exp_u[0] = 8'h00; exp_u[1] = 8'hFE; exp_u[2] = 8'hA1; exp_u[3] = 8'hA2;
        exp_u[4] = 8'hFF; exp_u[5] = 8'hA3; exp_u[6] = c[15:8]; exp_u[7] = c[7:0];
        start(8'h00, 1'b1, 12'd4);
        k = 0; n_done = 0;
        for (int i = 0; i < 8; i++) begin
            do_slot(i != 3, src[k], got, rdy);
            if (rdy && k < 3) k++;
            if (io_Done) n_done++;
            check($sformatf("und_byte%0d", i), got, exp_u[i]);
            if (i == 3) check("und_set", io_Underrun, 1'b1);
        end
        check("und_done", n_done, 1);
        check("und_sticky", io_Underrun, 1'b1);
        tick();
        check("und_still", io_Underrun, 1'b1);

        // ---- Cancel mid-DATA ----
        start(8'h00, 1'b1, 12'd4);
        check("can_und_clr", io_Underrun, 1'b0);
        do_slot(1'b1, 8'hB1, got, rdy);   // response -> token
        do_slot(1'b1, 8'hB1, got, rdy);   // token -> B1
        do_slot(1'b1, 8'hB2, got, rdy);   // B1 -> B2
        check("can_pre", io_OutputBuffer, 8'hB2);
        io_Cancel = 1'b1; io_ByteSlot = 1'b1; io_DataValid = 1'b1; io_DataIn = 8'hB3;
        #1;
        check("can_no_rdy", io_DataReady, 1'b0);
        tick();
        io_Cancel = 1'b0; io_ByteSlot = 1'b0; io_DataValid = 1'b0;
        check("can_idle", io_Busy, 1'b0);
        check("can_buf", io_OutputBuffer, 8'hFF);
        check("can_no_done", io_Done, 1'b0);
        start(8'h05, 1'b0, 12'd0);
        check("can_restart", io_OutputBuffer, 8'h05);
        do_slot(1'b0, 8'h00, got, rdy);
        check("can_restart_done", io_Done, 1'b1);

        // ---- Start with Cancel is dropped ----
        io_Cancel = 1'b1;
        start(8'h33, 1'b0, 12'd0);
        io_Cancel = 1'b0;
        check("sc_idle", io_Busy, 1'b0);
        check("sc_buf", io_OutputBuffer, 8'hFF);

        // ---- Start together with a slot in IDLE ----
        io_ByteSlot = 1'b1;
        start(8'h22, 1'b0, 12'd0);
        io_ByteSlot = 1'b0;
        check("ss_buf", io_OutputBuffer, 8'h22);
        check("ss_busy", io_Busy, 1'b1);
        do_slot(1'b0, 8'h00, got, rdy);
        check("ss_done", io_Done, 1'b1);

        // ---- Start ignored during RESP ----
        start(8'h01, 1'b0, 12'd0);
        start(8'h7E, 1'b1, 12'd3);
        check("ign_buf", io_OutputBuffer, 8'h01);
        check("ign_busy", io_Busy, 1'b1);
        do_slot(1'b0, 8'h00, got, rdy);
        check("ign_done", io_Done, 1'b1);
        check("ign_idle", io_Busy, 1'b0);

        // ---- Asynchronous reset in CRC_HI (empty block) ----
        start(8'h00, 1'b1, 12'd0);
        do_slot(1'b0, 8'h00, got, rdy);
        do_slot(1'b0, 8'h00, got, rdy);
        c = crc_wire(16'h0000);
        check("ar_crc_hi", io_OutputBuffer, c[15:8]);
        #2;
        reset = 1'b0;
        #1;
        check("ar_buf", io_OutputBuffer, 8'hFF);
        check("ar_busy", io_Busy, 1'b0);
        check("ar_done", io_Done, 1'b0);
        tick();
        reset = 1'b1;
        tick();
        check("ar_stay_idle", io_Busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
